// File: rtl/r5fp_fp2int_pkg.sv
// Shared definitions for the R5FP float-to-integer conversion pipeline:
// status-word bit positions, operand class encoding and integer limit helpers.
package r5fp_fp2int_pkg;

  // Bit positions inside the 8-bit R5FP status word.
  localparam int STATUS_INVALID = 2;
  localparam int STATUS_INEXACT = 5;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_NORMAL = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } fpClass_t;

  // Largest representable integer for a target width and signedness.
  // The unsigned 64-bit case wraps 1<<64 to 0, so the subtraction yields all ones.
  function automatic logic [63:0] maxInt(input int intW, input logic isSigned);
    return (64'd1 << (intW - (isSigned ? 1 : 0))) - 64'd1;
  endfunction

  // Most negative representable integer (two's complement pattern); 0 when unsigned.
  function automatic logic [63:0] minInt(input int intW, input logic isSigned);
    return isSigned ? (64'd1 << (intW - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/r5fp_fp2int_core.sv
// Combinational stage-2 datapath: aligns the significand, then saturates,
// negates and raises invalid/inexact with RISC-V fcvt semantics.
module r5fp_fp2int_core
  import r5fp_fp2int_pkg::*;
#(
  parameter int SIG_W = 23,
  parameter int EXP_W = 8,
  parameter int INT_W = 32
) (
  input  logic                    sign,
  input  logic signed [EXP_W:0]   expUnb,
  input  logic        [SIG_W:0]   sigFull,
  input  fpClass_t                cls,
  input  logic                    isSigned,
  input  logic                    inexact,
  output logic        [INT_W-1:0] intRes,
  output logic        [7:0]       status
);

  localparam int SH_W    = INT_W + SIG_W + 1;
  localparam int SHAMT_W = $clog2(SH_W);
  localparam logic signed [EXP_W:0] E_SIGNED_MAX = (EXP_W + 1)'(INT_W - 2);
  localparam logic signed [EXP_W:0] E_TOP        = (EXP_W + 1)'(INT_W - 1);

  logic               expNeg;
  logic               inRange;
  logic               fracZero;
  logic [SHAMT_W-1:0] shamt;
  logic [SH_W-1:0]    shifted;
  logic [INT_W-1:0]   mag;
  logic [INT_W-1:0]   maxPos;
  logic [INT_W-1:0]   minNeg;
  logic               invalid;

  assign expNeg   = expUnb[EXP_W];
  assign inRange  = !expNeg && (expUnb <= E_TOP);
  assign fracZero = (sigFull[SIG_W-1:0] == '0);

  // The significand sits right-aligned with its binary point at bit SIG_W;
  // shifting by e and dropping the low SIG_W bits yields the integer value.
  assign shamt   = inRange ? SHAMT_W'(expUnb) : '0;
  assign shifted = SH_W'(sigFull) << shamt;
  assign mag     = INT_W'(shifted >> SIG_W);

  assign maxPos = INT_W'(maxInt(INT_W, isSigned));
  assign minNeg = INT_W'(minInt(INT_W, isSigned));

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    intRes  = '0;
    invalid = 1'b0;
    unique case (cls)
      CLS_ZERO: intRes = '0;
      CLS_NAN: begin
        intRes  = maxPos;
        invalid = 1'b1;
      end
      CLS_INF: begin
        intRes  = sign ? minNeg : maxPos;
        invalid = 1'b1;
      end
      CLS_NORMAL: begin
        if (sign && !isSigned) begin
          invalid = 1'b1;
        end else if (expNeg) begin
          intRes = '0;
        end else if (isSigned) begin
          if (expUnb <= E_SIGNED_MAX) begin
            intRes = sign ? -mag : mag;
          end else begin
            // -2^(INT_W-1) is the single in-range value at the top exponent.
            intRes  = sign ? minNeg : maxPos;
            invalid = !(sign && (expUnb == E_TOP) && fracZero);
          end
        end else if (expUnb <= E_TOP) begin
          intRes = mag;
        end else begin
          intRes  = maxPos;
          invalid = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    status                 = '0;
    status[STATUS_INVALID] = invalid;
    status[STATUS_INEXACT] = inexact && !invalid;
  end

endmodule

// File: rtl/r5fp_fp2int_pipe.sv
// Two-register elastic pipeline converting an integral IEEE value to a signed
// or unsigned integer; stage 1 decodes the operand, stage 2 holds the result.
module r5fp_fp2int_pipe
  import r5fp_fp2int_pkg::*;
#(
  parameter int SIG_W = 23,
  parameter int EXP_W = 8,
  parameter int INT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SIG_W+EXP_W:0]   a_i,
  input  logic                   inexact_i,
  input  logic                   signed_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INT_W-1:0]       int_o,
  output logic [7:0]             status_o
);

  localparam int FP_W = SIG_W + EXP_W + 1;
  localparam logic [EXP_W:0] BIAS = (EXP_W + 1)'((1 << (EXP_W - 1)) - 1);

  logic                 inSign;
  logic [EXP_W-1:0]     inExp;
  logic [SIG_W-1:0]     inFrac;
  fpClass_t             inClass;

  logic                 v1;
  logic                 v2;
  logic                 load1;
  logic                 load2;
  logic                 accept;

  logic                 s1Sign;
  logic signed [EXP_W:0] s1Exp;
  logic [SIG_W:0]       s1Sig;
  fpClass_t             s1Class;
  logic                 s1Signed;
  logic                 s1Inexact;

  logic [INT_W-1:0]     coreInt;
  logic [7:0]           coreStatus;

  assign inSign = a_i[FP_W-1];
  assign inExp  = a_i[SIG_W +: EXP_W];
  assign inFrac = a_i[SIG_W-1:0];

  // Subnormals are folded into the zero class: they can only round to 0.
  always_comb begin
    inClass = CLS_NORMAL;
    if (inExp == '0) begin
      inClass = CLS_ZERO;
    end else if (inExp == '1) begin
      inClass = (inFrac == '0) ? CLS_INF : CLS_NAN;
    end
  end

  // Stage 1 may advance whenever it is empty or stage 2 is taking its beat,
  // which is exactly !v1 || !v2 || out_ready.
  assign load2     = !v2 || out_ready;
  assign load1     = !v1 || load2;
  assign in_ready  = load1;
  assign accept    = in_valid && in_ready;
  assign out_valid = v2;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
    end else if (load1) begin
      v1 <= accept;
    end
  end

  // NOTE: payload registers carry no reset; the valid bits alone decide
  // whether their contents are ever observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1Sign    <= inSign;
      s1Exp     <= $signed({1'b0, inExp} - BIAS);
      s1Sig     <= {1'b1, inFrac};
      s1Class   <= inClass;
      s1Signed  <= signed_i;
      s1Inexact <= inexact_i;
    end
  end

  r5fp_fp2int_core #(
    .SIG_W (SIG_W),
    .EXP_W (EXP_W),
    .INT_W (INT_W)
  ) u_core (
    .sign     (s1Sign),
    .expUnb   (s1Exp),
    .sigFull  (s1Sig),
    .cls      (s1Class),
    .isSigned (s1Signed),
    .inexact  (s1Inexact),
    .intRes   (coreInt),
    .status   (coreStatus)
  );

  // Outputs only change when a new beat moves in, so they hold under a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2       <= 1'b0;
      int_o    <= '0;
      status_o <= '0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        int_o    <= coreInt;
        status_o <= coreStatus;
      end
    end
  end

endmodule

// File: tb/tb_r5fp_fp2int_pipe.sv
// Scoreboard bench for r5fp_fp2int_pipe: directed vectors push expected
// results, a monitor pops and compares on every output transfer.
module tb_r5fp_fp2int_pipe;

  localparam logic [7:0] INV = 8'h04;
  localparam logic [7:0] INX = 8'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [31:0] aI;
  logic        inexI;
  logic        signedI;
  logic        outValid;
  logic        outReady;
  logic [31:0] intO;
  logic [7:0]  statusO;

  int checks   = 0;
  int failures = 0;
  logic [39:0] sb[$];
  bit txDone;

  r5fp_fp2int_pipe #(.SIG_W(23), .EXP_W(8), .INT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a_i       (aI),
    .inexact_i (inexI),
    .signed_i  (signedI),
    .out_valid (outValid),
    .out_ready (outReady),
    .int_o     (intO),
    .status_o  (statusO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one beat from posedge+1 until it is accepted, then records its expectation.
  task automatic send(input logic [31:0] a, input logic inx, input logic sgn,
                      input logic [31:0] expInt, input logic [7:0] expStat);
    logic ok;
    aI = a; inexI = inx; signedI = sgn; inValid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      ok = inReady;
      @(posedge clk);
      if (ok) break;
      if (n > 200) begin
        failures++;
        $display("FAIL send_timeout: a=0x%08h not accepted", a);
        #1 inValid = 1'b0;
        return;
      end
    end
    sb.push_back({expInt, expStat});
    #1 inValid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; sb.size() != 0; n++) begin
      @(negedge clk);
      if (n > 200) begin
        failures++;
        $display("FAIL drain_timeout: %0d results outstanding", sb.size());
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: a transfer happens at the next posedge when valid && ready hold now.
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (!reset && outValid && outReady) begin
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got int 0x%08h status 0x%02h", intO, statusO);
        end else begin
          e = sb.pop_front();
          check("result_int", intO, e[39:8]);
          check("result_status", statusO, e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; inValid = 1'b0; aI = '0; inexI = 1'b0; signedI = 1'b0; outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", outValid, 0);
    check("reset_int", intO, 0);
    check("reset_status", statusO, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", inReady, 1);

    // 123.0 signed with upstream inexact; out_valid appears 2 cycles after accept.
    send(32'h42F60000, 1'b1, 1'b1, 32'h0000007B, INX);
    @(negedge clk);
    check("latency_cycle1", outValid, 0);
    @(negedge clk);
    check("latency_cycle2", outValid, 1);
    @(posedge clk);
    #1;

    // Signed conversions and saturation.
    send(32'h4F000000, 1'b0, 1'b1, 32'h7FFFFFFF, INV);
    send(32'hCF000000, 1'b0, 1'b1, 32'h80000000, 8'h00);
    send(32'hCF000001, 1'b0, 1'b1, 32'h80000000, INV);
    send(32'h4EFFFFFF, 1'b0, 1'b1, 32'h7FFFFF80, 8'h00);
    send(32'hC2F60000, 1'b1, 1'b1, 32'hFFFFFF85, INX);
    send(32'hFF800000, 1'b0, 1'b1, 32'h80000000, INV);
    send(32'hFFC00000, 1'b1, 1'b1, 32'h7FFFFFFF, INV);
    send(32'h00000000, 1'b1, 1'b1, 32'h00000000, INX);
    // Unsigned conversions and saturation.
    send(32'hC0400000, 1'b0, 1'b0, 32'h00000000, INV);
    send(32'h80000000, 1'b0, 1'b0, 32'h00000000, 8'h00);
    send(32'h4F800000, 1'b0, 1'b0, 32'hFFFFFFFF, INV);
    send(32'h4F7FFFFF, 1'b0, 1'b0, 32'hFFFFFF00, 8'h00);
    send(32'hFFC00000, 1'b1, 1'b0, 32'hFFFFFFFF, INV);
    send(32'h7FC00001, 1'b0, 1'b0, 32'hFFFFFFFF, INV);
    send(32'h7F800000, 1'b0, 1'b0, 32'hFFFFFFFF, INV);
    send(32'hFF800000, 1'b0, 1'b0, 32'h00000000, INV);
    send(32'h3F800000, 1'b1, 1'b0, 32'h00000001, INX);
    drain();

    // Backpressure: four back-to-back beats against a stalled consumer.
    outReady = 1'b0;
    txDone   = 1'b0;
    fork
      begin
        send(32'h3F800000, 1'b0, 1'b1, 32'd1, 8'h00);
        send(32'h40000000, 1'b0, 1'b1, 32'd2, 8'h00);
        send(32'h40400000, 1'b0, 1'b1, 32'd3, 8'h00);
        send(32'h40800000, 1'b0, 1'b1, 32'd4, 8'h00);
        txDone = 1'b1;
      end
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("bp_accepted_two", sb.size(), 2);
    check("bp_in_ready_low", inReady, 0);
    check("bp_out_valid", outValid, 1);
    check("bp_int_first", intO, 1);
    @(posedge clk);
    @(negedge clk);
    check("bp_int_held", intO, 1);
    check("bp_in_ready_held", inReady, 0);
    @(posedge clk);
    #1 outReady = 1'b1;
    for (int n = 0; !txDone; n++) begin
      @(posedge clk);
      if (n > 200) begin
        failures++;
        $display("FAIL bp_send_timeout: stream not accepted");
        break;
      end
    end
    drain();

    // Reset with both stages full drops both beats.
    outReady = 1'b0;
    send(32'h40C00000, 1'b0, 1'b1, 32'd6, 8'h00);
    send(32'h40E00000, 1'b0, 1'b1, 32'd7, 8'h00);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    check("rst_mid_out_valid", outValid, 0);
    check("rst_mid_int", intO, 0);
    check("rst_mid_in_ready", inReady, 1);
    outReady = 1'b1;
    send(32'h40A00000, 1'b0, 1'b1, 32'd5, 8'h00);
    @(negedge clk);
    check("rst_latency_cycle1", outValid, 0);
    @(negedge clk);
    check("rst_latency_cycle2", outValid, 1);
    @(posedge clk);
    #1;
    drain();
    repeat (4) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
